// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame sequencer for the 3x3 convolution datapath
// Tracks raster position, tags complete windows through the pipeline, flags s_tlast mismatches.
module conv_frame_sequencer #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int PIPE_LAT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic s_tvalid_i,
  output logic s_tready_o,
  input  logic s_tlast_i,
  output logic m_tvalid_o,
  input  logic m_tready_i,
  output logic m_tlast_o,
  output logic pix_en_o,
  output logic pipe_en_o,
  output logic busy_o,
  output logic frame_done_o,
  output logic err_tlast_o
);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);
  localparam int OW   = $clog2(NOUT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [OW-1:0]       out_cnt_q;
  logic [PIPE_LAT-1:0] vld_q;
  logic [PIPE_LAT-1:0] vld_d;
  logic                err_q;

  logic active;
  logic out_hs;
  logic px_last;
  logic slot_in;

  // Reset gates the ready/advance strobes so nothing is accepted in the reset cycle.
  always_comb begin
    active       = ((state_q == RUN) || (state_q == FLUSH)) && !rst_i;
    m_tvalid_o   = vld_q[PIPE_LAT-1];
    pipe_en_o    = active && (m_tready_i || !m_tvalid_o);
    s_tready_o   = pipe_en_o && (state_q == RUN);
    pix_en_o     = s_tvalid_i && s_tready_o;
    m_tlast_o    = m_tvalid_o && (out_cnt_q == OUT_LAST);
    out_hs       = m_tvalid_o && m_tready_i;
    frame_done_o = active && out_hs && m_tlast_o;
    busy_o       = (state_q == RUN) || (state_q == FLUSH);
    err_tlast_o  = err_q;
    px_last      = (row_q == ROW_LAST) && (col_q == COL_LAST);
    slot_in      = pix_en_o && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    vld_d        = (vld_q << 1) | PIPE_LAT'(slot_in);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      vld_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= RUN;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
          end
        end
        RUN, FLUSH: begin
          if (pipe_en_o) vld_q <= vld_d;
          if (pix_en_o) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            // Upstream tlast is only cross-checked; the frame ends by pixel count.
            if (s_tlast_i != px_last) err_q <= 1'b1;
            if (px_last) state_q <= FLUSH;
          end
          if (out_hs) out_cnt_q <= out_cnt_q + OW'(1);
          if (frame_done_o) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
